// File: rtl/exec_pkg.sv
// Shared definitions for the exec sequencer: opcodes, FSM states and instruction field helpers.
// Instruction layout: [15:12] op, [11:8] D, [7:4] S, [7:0] imm8 (LDI only).
package exec_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic [3:0] instrOp(input logic [15:0] i);
    return i[15:12];
  endfunction

  function automatic logic [3:0] instrD(input logic [15:0] i);
    return i[11:8];
  endfunction

  function automatic logic [3:0] instrS(input logic [15:0] i);
    return i[7:4];
  endfunction

  function automatic logic [7:0] instrImm(input logic [15:0] i);
    return i[7:0];
  endfunction

  // NOP and CMP go through the full pipeline but never touch the register file.
  function automatic logic opWrites(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the exec sequencer: computes result, {ovf, neg, zero} and opcode legality.
// All arithmetic is modulo 2^DATA_W; shifts use only the low 4 bits of the S operand.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [7:0]        i_imm8,
  output logic [DATA_W-1:0] o_res,
  output logic [2:0]        o_flags,
  output logic              o_illegal
);

  localparam int MSB = DATA_W - 1;

  logic                     w_ovf;
  int                       w_shamt;
  logic signed [DATA_W-1:0] w_aSigned;

  always_comb begin
    o_res     = i_a;
    w_ovf     = 1'b0;
    o_illegal = 1'b0;
    w_shamt   = int'(i_b[3:0]);
    w_aSigned = i_a;
    case (i_op)
      OP_NOP: o_res = i_a;
      OP_ADD: begin
        o_res = i_a + i_b;
        w_ovf = (i_a[MSB] == i_b[MSB]) && (o_res[MSB] != i_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        o_res = i_a - i_b;
        w_ovf = (i_a[MSB] != i_b[MSB]) && (o_res[MSB] != i_a[MSB]);
      end
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_MOV: o_res = i_b;
      OP_LDI: o_res = {{(DATA_W-8){i_imm8[7]}}, i_imm8};
      OP_SHL: begin
        if (w_shamt >= DATA_W) o_res = '0;
        else                   o_res = i_a << i_b[3:0];
      end
      // Kept as a separate signed statement so the arithmetic shift is not demoted to logical.
      OP_SAR: begin
        if (w_shamt >= DATA_W) o_res = {DATA_W{i_a[MSB]}};
        else                   o_res = w_aSigned >>> i_b[3:0];
      end
      default: o_illegal = 1'b1;
    endcase
    o_flags = {w_ovf, o_res[MSB], (o_res == '0)};
  end

endmodule

// File: rtl/exec_sequencer.sv
// Non-pipelined issue/execute stage: IDLE -> READ -> EXEC -> WRITE, one instruction in flight.
// Reads D/S through the register file's registered ports and writes the ALU result back to D.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int REG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              rf_rd_en,
  output logic              rf_rs_en,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [ADDR_W-1:0] rf_rs_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic              rf_valid,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [2:0]        flags,
  output logic              err
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [15:0]       r_instr;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_flags;
  logic              r_err;

  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_aluRes;
  logic [2:0]        w_aluFlags;
  logic              w_aluIllegal;
  logic              w_addrIllegal;
  logic              w_issueIllegal;

  // The ALU also decodes legality of the instruction being offered while idle.
  assign w_op = (r_state == ST_IDLE) ? instrOp(instr) : instrOp(r_instr);

  // LDI reuses the S field as immediate bits, so only D is range-checked for it.
  assign w_addrIllegal = (int'(instrD(instr)) >= REG_DEPTH) ||
                         ((instrOp(instr) != OP_LDI) && (int'(instrS(instr)) >= REG_DEPTH));
  assign w_issueIllegal = w_aluIllegal || w_addrIllegal;

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op      (w_op),
    .i_a       (rf_rd_data),
    .i_b       (rf_rs_data),
    .i_imm8    (instrImm(r_instr)),
    .o_res     (w_aluRes),
    .o_flags   (w_aluFlags),
    .o_illegal (w_aluIllegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext  = r_state;
    instr_ready  = 1'b0;
    rf_rd_en     = 1'b0;
    rf_rs_en     = 1'b0;
    rf_wr_en     = 1'b0;
    rf_rd_addr   = '0;
    rf_rs_addr   = '0;
    rf_wr_data   = '0;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && !w_issueIllegal) w_stateNext = ST_READ;
      end
      ST_READ: begin
        rf_rd_en    = 1'b1;
        rf_rs_en    = 1'b1;
        rf_rd_addr  = ADDR_W'(instrD(r_instr));
        rf_rs_addr  = ADDR_W'(instrS(r_instr));
        w_stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        w_stateNext = rf_valid ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE: begin
        rf_wr_en     = opWrites(instrOp(r_instr));
        rf_rd_addr   = ADDR_W'(instrD(r_instr));
        rf_wr_data   = r_result;
        result_valid = 1'b1;
        w_stateNext  = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // err is a registered pulse, so it lands the cycle after the offending IDLE or EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == ST_IDLE) && instr_valid) begin
        if (w_issueIllegal) r_err   <= 1'b1;
        else                r_instr <= instr;
      end
      if (r_state == ST_EXEC) begin
        if (!rf_valid) begin
          r_err <= 1'b1;
        end else begin
          r_result <= w_aluRes;
          if (instrOp(r_instr) != OP_NOP) r_flags <= w_aluFlags;
        end
      end
    end
  end

  assign result = r_result;
  assign flags  = r_flags;
  assign err    = r_err;

endmodule
